// File: rtl/ifb_pkg.sv
// ifb_pkg: shared types and constants for the instruction fetch buffer
package ifb_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] IFB_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP
  } ifb_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } ifb_entry_t;

  // Fetch addresses are always word aligned; low bits from the selector are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo: DEPTH-entry synchronous FIFO of {pc, inst}; clear beats push/pop
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  ifb_entry_t wdata_i,
  output ifb_entry_t rdata_o,
  output logic [AW:0] count_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

  ifb_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == CAP;
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  // A pop frees the slot the push lands in, so push at full is fine when popping.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk)
    if (!rst_n || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk)
    if (do_push && !clear_i) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: fetch PC, single-outstanding imem requests, queued hand-off to decode.
// Define IFB_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFB_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_current,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  localparam int AW = $clog2(DEPTH);
`ifdef IFB_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  ifb_state_e  state_q;
  logic [31:0] pc_q, tag_q;
  logic        gnt, byp, push, pop, full, empty;
  logic [AW:0] count;
  ifb_entry_t  head;

  // Pops in the same cycle do not free a slot for a new request.
  assign imem_req   = rst_n && state_q == S_RUN && !full;
  assign gnt        = imem_req && imem_gnt;
  assign imem_addr  = pc_q;
  assign pc_current = pc_q;

  assign byp      = BYP_EN && state_q == S_WAIT && imem_rvalid && !flush && count == '0;
  assign id_valid = rst_n && (!empty || byp);
  assign id_pc    = byp ? tag_q : head.pc;
  assign id_inst  = byp ? imem_rdata : head.inst;
  assign push     = state_q == S_WAIT && imem_rvalid && !flush && !(byp && id_ready);
  assign pop      = id_valid && id_ready && !byp;

  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .clear_i(flush),
    .wdata_i('{pc: tag_q, inst: imem_rdata}),
    .rdata_o(head),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

  // Fetch FSM with the architectural PC; a flush kills any in-flight response.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      tag_q   <= RESET_PC;
    end else if (flush) begin
      pc_q    <= word_align(redirect_pc);
      state_q <= state_q == S_RUN ? (gnt ? S_DROP : S_RUN) : (imem_rvalid ? S_RUN : S_DROP);
    end else begin
      case (state_q)
        S_RUN:
          if (gnt) begin
            pc_q    <= word_align(next_pc);
            tag_q   <= pc_q;
            state_q <= S_WAIT;
          end
        default:
          if (imem_rvalid) state_q <= S_RUN;
      endcase
    end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed cycle-accurate checks of fetch, backpressure and flush
module tb_ifetch_buffer;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] next_pc, redirect_pc = '0;
  logic        flush = 1'b0, id_ready = 1'b0, gnt_en = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, id_valid;
  logic [31:0] imem_addr, imem_rdata, pc_current, id_pc, id_inst;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0, lat = 0;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] got[$], exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  ifetch_buffer #(.RESET_PC(32'h100), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_current(pc_current),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  // PC selector: sequential prediction
  assign next_pc = pc_current + 32'd4;

  // Instruction memory: responds lat cycles after the cycle following a grant
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = pend && pend_wait == 0;
  assign imem_rdata  = inst_of(pend_addr);
  always @(posedge clk)
    if (!rst_n) pend <= 1'b0;
    else if (imem_req && imem_gnt) begin
      pend      <= 1'b1;
      pend_addr <= imem_addr;
      pend_wait <= lat;
    end else if (imem_rvalid) pend <= 1'b0;
    else if (pend) pend_wait <= pend_wait - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Decode side: record every accepted instruction
  always @(negedge clk)
    if (rst_n && id_valid && id_ready && !flush) begin
      got.push_back(id_pc);
      chk("id_inst", id_inst, inst_of(id_pc));
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    mid();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(id_valid), 0);
    // cycle 0
    step(); rst_n = 1'b1; id_ready = 1'b1; mid();
    chk("c0_req", 32'(imem_req), 1);
    chk("c0_addr", imem_addr, 32'h100);
    chk("c0_valid", 32'(id_valid), 0);
    // cycle 1: response
    step(); mid();
    chk("c1_valid", 32'(id_valid), 32'(BYP));
    chk("c1_req", 32'(imem_req), 0);
    // cycle 2
    step(); mid();
    chk("c2_valid", 32'(id_valid), 32'(!BYP));
    chk("c2_pc", id_valid ? id_pc : 32'h0, BYP ? 32'h0 : 32'h100);
    chk("c2_req", 32'(imem_req), 1);
    chk("c2_addr", imem_addr, 32'h104);
    repeat (4) step();
    mid();
    chk("c6_req", 32'(imem_req), 1);
    chk("c6_addr", imem_addr, 32'h10C);
    // cycles 7..16: decode stalled
    step(); id_ready = 1'b0;
    repeat (9) step();
    mid();
    chk("stall_req", 32'(imem_req), 0);
    chk("stall_valid", 32'(id_valid), 1);
    chk("stall_pc", id_pc, 32'h10C);
    // cycle 17: release
    step(); id_ready = 1'b1; mid();
    chk("rel0_pc", id_pc, 32'h10C);
    chk("rel0_req", 32'(imem_req), 0);
    step(); mid();
    chk("rel1_valid", 32'(id_valid), 1);
    chk("rel1_pc", id_pc, 32'h110);
    chk("rel1_req", 32'(imem_req), 1);
    chk("rel1_addr", imem_addr, 32'h114);
    step(); mid();
    chk("c19_valid", 32'(id_valid), 32'(BYP));
    // cycle 20: hold off grants to settle into RUN/empty
    step(); gnt_en = 1'b0; mid();
    chk("c20_valid", 32'(id_valid), 32'(!BYP));
    step(); mid();
    chk("idle_valid", 32'(id_valid), 0);
    chk("idle_req", 32'(imem_req), 1);
    chk("idle_addr", imem_addr, 32'h118);
    // flush while a request is outstanding
    step(); gnt_en = 1'b1; lat = 2;
    step(); flush = 1'b1; redirect_pc = 32'h200; mid();
    chk("wait_req", 32'(imem_req), 0);
    step(); flush = 1'b0; mid();
    chk("drop_req", 32'(imem_req), 0);
    chk("drop_addr", imem_addr, 32'h200);
    chk("drop_valid", 32'(id_valid), 0);
    step(); lat = 0; mid();
    chk("drop_rsp_valid", 32'(id_valid), 0);
    chk("drop_rsp_req", 32'(imem_req), 0);
    step(); mid();
    chk("redir_req", 32'(imem_req), 1);
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_valid", 32'(id_valid), 0);
    step(); mid();
    chk("c27_valid", 32'(id_valid), 32'(BYP));
    chk("c27_pc", id_valid ? id_pc : 32'h0, BYP ? 32'h200 : 32'h0);
    step(); id_ready = 1'b0; mid();
    chk("c28_pc", id_valid ? id_pc : 32'h0, BYP ? 32'h0 : 32'h200);
    // flush together with rvalid and pop
    step(); id_ready = 1'b1; flush = 1'b1; redirect_pc = 32'h300; mid();
    chk("frv_req", 32'(imem_req), 0);
    // flush together with a grant
    step(); redirect_pc = 32'h400; lat = 1; mid();
    chk("frv_valid", 32'(id_valid), 0);
    chk("frv_req_after", 32'(imem_req), 1);
    chk("frv_addr", imem_addr, 32'h300);
    step(); flush = 1'b0; mid();
    chk("fg_req", 32'(imem_req), 0);
    chk("fg_addr", imem_addr, 32'h400);
    chk("fg_valid", 32'(id_valid), 0);
    step(); lat = 0; mid();
    chk("fg_rsp_req", 32'(imem_req), 0);
    chk("fg_rsp_valid", 32'(id_valid), 0);
    step(); mid();
    chk("fg_run_req", 32'(imem_req), 1);
    chk("fg_run_addr", imem_addr, 32'h400);
    chk("fg_run_valid", 32'(id_valid), 0);
    step(); mid();
    chk("c34_valid", 32'(id_valid), 32'(BYP));
    step(); mid();
    chk("c35_pc", id_valid ? id_pc : 32'h0, BYP ? 32'h0 : 32'h400);
    repeat (3) step();
    mid();
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
    if (BYP) exp_q.push_back(32'h200);
    exp_q.push_back(32'h400);
    exp_q.push_back(32'h404);
    chk("pop_count", 32'(got.size() >= exp_q.size()), 1);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("pop_seq%0d", i), i < got.size() ? got[i] : 32'hFFFF_FFFF, exp_q[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
